// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: pin conditioning, frame checking with parity/stop/watchdog,
// and a show-ahead byte FIFO towards the keyboard/mouse decode logic.
module ps2_rx_fifo #(
    parameter int unsigned FILTER_LEN   = 8,
    parameter int unsigned SAMPLE_DELAY = 130,
    parameter int unsigned TIMEOUT      = 3700,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned PARITY_EN    = 1
) (
    input  logic                          ck,
    input  logic                          reset,
    input  logic                          ps2_clk,
    input  logic                          ps2_data,
    input  logic                          rd_en,
    output logic [7:0]                    rd_data,
    output logic                          rd_valid,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          parity_err,
    output logic                          frame_err,
    output logic                          overflow,
    output logic                          timeout
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned FW = $clog2(FILTER_LEN + 1);
    localparam int unsigned DW = $clog2(SAMPLE_DELAY + 1);
    localparam int unsigned WW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, DELAY, SAMPLE, WAIT_EDGE, CHECK} state_t;

    logic [1:0]    clk_sync;
    logic [1:0]    data_sync;
    logic          fclk;
    logic          fe;
    logic [FW-1:0] fcnt;
    state_t        state;
    logic [3:0]    idx;
    logic [10:1]   frame;
    logic [DW-1:0] dcnt;
    logic [WW-1:0] wd;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [CW-1:0] cnt_nxt;
    logic          pop_c;
    logic          stop_bad_c;
    logic          par_bad_c;
    logic          ovf_c;
    logic          wr_c;

    // Two-flop synchronisers; idle PS/2 lines are high
    always_ff @(posedge ck or posedge reset) begin
        if (reset) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
        end
    end

    // Glitch filter: new level must persist FILTER_LEN samples; fe marks a filtered fall
    always_ff @(posedge ck or posedge reset) begin
        if (reset) begin
            fclk <= 1'b1;
            fcnt <= '0;
            fe   <= 1'b0;
        end else begin
            fe <= 1'b0;
            if (clk_sync[1] == fclk) begin
                fcnt <= '0;
            end else if (fcnt == FW'(FILTER_LEN - 1)) begin
                fclk <= clk_sync[1];
                fcnt <= '0;
                fe   <= fclk;
            end else begin
                fcnt <= fcnt + FW'(1);
            end
        end
    end

    // Frame acceptance decision, shared by the FSM flags and the FIFO write
    always_comb begin
        pop_c      = rd_en && rd_valid;
        stop_bad_c = !frame[10];
        par_bad_c  = (PARITY_EN != 0) && !(^frame[9:1]);
        ovf_c      = full && !pop_c;
        wr_c       = (state == CHECK) && !stop_bad_c && !par_bad_c && !ovf_c;
        cnt_nxt    = count + CW'(wr_c) - CW'(pop_c);
    end

    // Receive FSM with watchdog; wd counts cycles since the last fe, that cycle included
    always_ff @(posedge ck or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            idx        <= '0;
            frame      <= '0;
            dcnt       <= '0;
            wd         <= '0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overflow   <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overflow   <= 1'b0;
            timeout    <= 1'b0;
            if (fe)
                wd <= WW'(1);
            else if (state == IDLE)
                wd <= '0;
            else
                wd <= wd + WW'(1);

            case (state)
                IDLE: if (fe) begin
                    state <= DELAY;
                    idx   <= '0;
                    dcnt  <= '0;
                end
                DELAY: begin
                    if (dcnt == DW'(SAMPLE_DELAY - 1))
                        state <= SAMPLE;
                    else
                        dcnt <= dcnt + DW'(1);
                end
                SAMPLE: begin
                    if (idx == 4'd0) begin
                        state <= data_sync[1] ? IDLE : WAIT_EDGE;
                        idx   <= 4'd1;
                    end else begin
                        frame[idx] <= data_sync[1];
                        if (idx == 4'd10) begin
                            state <= CHECK;
                        end else begin
                            idx   <= idx + 4'd1;
                            state <= WAIT_EDGE;
                        end
                    end
                end
                WAIT_EDGE: if (fe) begin
                    state <= DELAY;
                    dcnt  <= '0;
                end
                CHECK: begin
                    state <= IDLE;
                    if (stop_bad_c)
                        frame_err <= 1'b1;
                    else if (par_bad_c)
                        parity_err <= 1'b1;
                    else if (ovf_c)
                        overflow <= 1'b1;
                end
                default: state <= IDLE;
            endcase

            if ((state == DELAY || state == SAMPLE || state == WAIT_EDGE)
                && !fe && wd == WW'(TIMEOUT - 1)) begin
                state   <= IDLE;
                timeout <= 1'b1;
            end
        end
    end

    // Show-ahead FIFO; simultaneous write and pop is accepted even when full
    always_ff @(posedge ck or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++)
                mem[i] <= 8'h00;
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            rd_valid <= 1'b0;
            full     <= 1'b0;
        end else begin
            if (wr_c) begin
                mem[wptr] <= frame[8:1];
                wptr      <= wptr + AW'(1);
            end
            if (pop_c)
                rptr <= rptr + AW'(1);
            count    <= cnt_nxt;
            rd_valid <= (cnt_nxt != '0);
            full     <= (cnt_nxt == CW'(FIFO_DEPTH));
        end
    end

    assign rd_data = mem[rptr];

endmodule

// File: doc/ps2_rx_fifo.md
# ps2_rx_fifo

Parametrised PS/2 device-to-host receiver with input conditioning, full frame checking, a mid-frame watchdog and an output FIFO. It sits between the PS/2 pins and the keyboard/mouse decode logic, where it replaces the fixed 11-bit reader. It adds error reporting, parity modes and buffering of several bytes, so consumers can read at their own pace.

## Interface
Parameters:
- FILTER_LEN, 8: consecutive cycles ps2_clk must hold a new level before the filtered clock changes (≥2).
- SAMPLE_DELAY, 130: cycles from filtered falling edge to data sample (≥1).
- TIMEOUT, 3700: maximum cycles between falling edges inside a frame (≥SAMPLE_DELAY+4).
- FIFO_DEPTH, 4: byte entries; power of 2, ≥2.
- PARITY_EN, 1: 1 = odd parity checked; 0 = parity bit ignored.

Ports:
- ck  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high.
- ps2_clk  in  1  raw PS/2 clock pin.
- ps2_data  in  1  raw PS/2 data pin.
- rd_en  in  1  pop request.
- rd_data  out  8  head byte, valid while rd_valid.
- rd_valid  out  1  FIFO not empty.
- full  out  1  FIFO holds FIFO_DEPTH bytes.
- count  out  $clog2(FIFO_DEPTH)+1  occupancy.
- parity_err  out  1  1-cycle pulse.
- frame_err  out  1  1-cycle pulse, stop bit 0.
- overflow  out  1  1-cycle pulse, good byte dropped.
- timeout  out  1  1-cycle pulse, frame aborted.

## Operation
- Conditioning: ps2_clk and ps2_data pass through 2-flop synchronisers, reset to 1. The filtered clock (reset 1) takes the synchronised value only after FILTER_LEN consecutive equal samples. fe = 1-cycle pulse on a filtered 1→0 transition.
- FSM states: IDLE, DELAY, SAMPLE, WAIT_EDGE, CHECK.
  - IDLE: on fe → DELAY, bit index 0.
  - DELAY: counts SAMPLE_DELAY cycles → SAMPLE.
  - SAMPLE: one cycle; captures synchronised data into bit[index].
    - Index 0 with data 1 → IDLE silently (glitch start).
    - Index 10 → CHECK.
    - Otherwise index+1 → WAIT_EDGE.
  - WAIT_EDGE: on fe → DELAY.
  - CHECK: one cycle, then IDLE.
- Frame layout: bit0 start=0; bits1–8 data, LSB first; bit9 parity; bit10 stop.
- CHECK priority:
  1. stop=0 → frame_err.
  2. PARITY_EN and XOR(bits1–9)=0 → parity_err.
  3. FIFO full with no pop in the same cycle → overflow.
  4. Otherwise write the byte.
  - Only one flag fires per frame. A rejected frame never writes.
- Watchdog: counter cleared in IDLE and on every fe, counting in all other states. Reaching TIMEOUT → timeout pulse, back to IDLE, partial frame discarded.
- FIFO:
  - Show-ahead: rd_data = entry at the read pointer.
  - Pop when rd_en && rd_valid; rd_en while empty is ignored.
  - Pointers wrap modulo FIFO_DEPTH.
  - Write and pop in the same cycle: count unchanged. This also applies when full; the write is then accepted.
- Reset (any time, including mid-frame): FSM IDLE, FIFO empty, counters 0, all outputs 0 (rd_data 0), filtered clock 1. A frame in flight is lost.

## Timing
- Raw pin edge → fe: 2 (sync) + FILTER_LEN cycles.
- fe → SAMPLE capture edge: SAMPLE_DELAY+1 cycles.
- Stop-bit SAMPLE cycle → CHECK next cycle → FIFO write on the CHECK end edge. rd_valid/count update the following cycle, i.e. 2 cycles after the stop sample.
- Error/overflow pulses are asserted for exactly the cycle after CHECK (registered).
- Pop: rd_data shows the next entry, and count decrements, on the cycle after the rd_en edge.
- Back-to-back frames: a fe in CHECK is not seen. PS/2 idle time between frames far exceeds 1 cycle, so no requirement applies there.

## Test plan
Bench parameters: FILTER_LEN=4, SAMPLE_DELAY=10, TIMEOUT=200, FIFO_DEPTH=4, PARITY_EN=1; PS/2 bit period 100 cycles.
- Send 0x1C (parity 0, stop 1) → rd_valid=1, rd_data=0x1C, count=1, no flags; then rd_en 1 cycle → rd_valid=0, count=0.
- Send 0xF0 with parity forced 0 → parity_err pulse, count stays 0. Repeat with PARITY_EN=0 → 0xF0 stored.
- Send 0x55 with stop=0 → frame_err pulse, no write. Single 2-cycle ps2_clk low glitch → no fe, FSM stays IDLE.
- Send 5 bytes 0x01–0x05 without reading → full=1 after the 4th, overflow pulse on the 5th. Pops return 0x01..0x04 in order. Then fill again to check wrap-around order.
- Full FIFO; 5th frame CHECK coincides with rd_en → no overflow, count stays 4, tail byte = 5th.
- Stop ps2_clk high after bit 4 → timeout pulse 200 cycles after the last fe, FSM IDLE. Assert reset mid-frame → all outputs 0, next clean frame 0x2A received correctly.
